masked_share_encoder: RTL
=========================

# masked_share_encoder

Produces the two-share masked form of plaintext operand bits A and B, plus one fresh mask bit r0, for the masked half-adder and the other masked gadgets on this side of the design. Share randomness comes from an internal free-running 16-bit Fibonacci LFSR, and software can reseed it. Each output tuple sits in a single-entry registered output stage with a valid/ready handshake. All share outputs come from flops, as PROLEAD evaluation requires.

## Interface
- LFSR_W, 16: LFSR width. The polynomial below is defined for 16 only.
- SEED, 16'hACE1: LFSR value after reset, and the value substituted for an all-zero seed.
- clk  in  1  clock; everything is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- seed_load  in  1  loads seed_in into the LFSR this cycle.
- seed_in  in  LFSR_W  new LFSR value.
- in_valid  in  1  a plaintext operand pair is present.
- in_ready  out  1  the encoder accepts the pair this cycle.
- i_A, i_B  in  1 each  plaintext bits.
- o_valid  out  1  the output tuple is valid.
- o_ready  in  1  the consumer takes the tuple.
- o_A0, o_A1, o_B0, o_B1  out  1 each  shares of A and B.
- o_r0  out  1  fresh randomness for the gadget.
- o_count  out  8  number of tuples issued; wraps from 255 to 0.

## Operation
- LFSR:
  - Shifts left every cycle.
  - Feedback = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10], inserted at bit 0 (polynomial x^16+x^14+x^13+x^11+1).
  - When seed_load=1, the LFSR loads seed_in next cycle instead of shifting.
  - If seed_in==0, it loads SEED, so the LFSR never holds zero.
- Accept condition: in_valid && in_ready.
  - in_ready = !seed_load && (!o_valid || o_ready). Pass-through ready: a full stage drained this cycle can be refilled in the same cycle.
- On accept, the mask bits are taken from the current (pre-shift) LFSR value: m_a=lfsr[0], m_b=lfsr[1], m_r=lfsr[2].
- The output registers then load:
  - o_A0=i_A^m_a, o_A1=m_a
  - o_B0=i_B^m_b, o_B1=m_b
  - o_r0=m_r
  - o_valid=1
  - o_count increments.
- Drain without accept (o_valid && o_ready, no accept): o_valid goes to 0. The share outputs hold their last values.
- Stall (o_valid && !o_ready): all outputs are held stable.
- Invariants for every issued tuple: o_A0^o_A1==A and o_B0^o_B1==B.
- Neither plaintext bit is ever registered or driven unmasked.
- State: EMPTY (o_valid=0) and FULL (o_valid=1).
  - EMPTY→FULL on accept.
  - FULL→FULL on accept with o_ready.
  - FULL→EMPTY on o_ready with no accept.
  - FULL stays FULL on stall.

## Timing
- Reset (asynchronous, rst_n=0): lfsr=SEED; o_valid=0; o_A0, o_A1, o_B0, o_B1, o_r0 = 0; o_count=0.
- in_ready is low during reset and follows its equation after reset releases.
- Latency: one cycle from accept to o_valid.
- Throughput: one tuple per cycle while o_ready=1.
- seed_load wins over any accept in the same cycle; in_ready=0 that cycle.
- Mask bits used in the cycle after a seed_load come from the newly loaded value.
- Reset mid-transaction discards the pending tuple. No partial outputs remain.
- o_count wraps from 255 to 0 with no flag.

## Test plan
- Reset, release, then in_valid=1 with A=1, B=0 in the first cycle → next cycle: o_valid=1, o_A0=0, o_A1=1, o_B0=0, o_B1=0, o_r0=0, o_count=1. The LFSR has moved from 0xACE1 to 0x59C3.
- Back-to-back stream with o_ready=1 for 300 cycles, random A/B:
  - every tuple satisfies the share XOR invariants
  - in_ready stays 1
  - o_count reads 44 (300 mod 256).
- Backpressure: hold o_ready=0 for 5 cycles while in_valid=1 → outputs are stable and in_ready=0. Raising o_ready → the next tuple is accepted in the same cycle.
- seed_load=1 with seed_in=0 together with in_valid=1 → no accept that cycle; the LFSR reads 0xACE1 next cycle.
- seed_load with seed_in=0x0007, then an accept → m_a=1, m_b=1, m_r=1. For A=0, B=1: o_A0=1, o_B0=0, o_r0=1.
- Drop rst_n to 0 asynchronously mid-stall → outputs and o_count clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/masked_share_encoder_if.sv
// Handshake and share bus between a plaintext producer and the masked share encoder.
// The master side presents operand pairs and consumes share tuples; the slave side is the encoder.
interface masked_share_encoder_if;
    logic       in_valid;
    logic       in_ready;
    logic       i_A;
    logic       i_B;
    logic       o_valid;
    logic       o_ready;
    logic       o_A0;
    logic       o_A1;
    logic       o_B0;
    logic       o_B1;
    logic       o_r0;
    logic [7:0] o_count;

    modport master (
        output in_valid, i_A, i_B, o_ready,
        input  in_ready, o_valid, o_A0, o_A1, o_B0, o_B1, o_r0, o_count
    );

    modport slave (
        input  in_valid, i_A, i_B, o_ready,
        output in_ready, o_valid, o_A0, o_A1, o_B0, o_B1, o_r0, o_count
    );
endinterface

// File: rtl/masked_share_encoder.sv
// Two-share Boolean masking of plaintext bits A and B plus one fresh mask bit, with
// masks drawn from a free-running reseedable 16-bit Fibonacci LFSR; all shares are registered.
module masked_share_encoder #(
    parameter int unsigned          LFSR_W = 16,
    parameter logic [LFSR_W-1:0]    SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    masked_share_encoder_if.slave bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_next;
    logic              feedback;
    logic              ready;
    logic              accept;
    logic              share_a0;
    logic              share_a1;
    logic              share_b0;
    logic              share_b1;
    logic              share_r0;
    logic [7:0]        count;

    // Taps for x^16+x^14+x^13+x^11+1; an all-zero seed would lock the register, so SEED replaces it.
    always_comb begin
        feedback  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
        lfsr_next = {lfsr[LFSR_W-2:0], feedback};
        if (seed_load) begin
            lfsr_next = (seed_in == '0) ? SEED : seed_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else begin
            lfsr <= lfsr_next;
        end
    end

    // Ready gated by rst_n so it reads low throughout reset; a reseed cycle never accepts.
    always_comb begin
        state_next = state;
        ready      = rst_n && !seed_load && ((state == EMPTY) || bus.o_ready);
        accept     = bus.in_valid && ready;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    state_next = FULL;
                end else if (bus.o_ready) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Plaintext bits only ever reach a flop already XORed with a mask bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            share_a0 <= 1'b0;
            share_a1 <= 1'b0;
            share_b0 <= 1'b0;
            share_b1 <= 1'b0;
            share_r0 <= 1'b0;
            count    <= '0;
        end else if (accept) begin
            share_a0 <= bus.i_A ^ lfsr[0];
            share_a1 <= lfsr[0];
            share_b0 <= bus.i_B ^ lfsr[1];
            share_b1 <= lfsr[1];
            share_r0 <= lfsr[2];
            count    <= count + 8'd1;
        end
    end

    assign bus.in_ready = ready;
    assign bus.o_valid  = (state == FULL);
    assign bus.o_A0     = share_a0;
    assign bus.o_A1     = share_a1;
    assign bus.o_B0     = share_b0;
    assign bus.o_B1     = share_b1;
    assign bus.o_r0     = share_r0;
    assign bus.o_count  = count;

endmodule
